// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
//   Shared types and constants for the pipeline stall/flush controller.
//   - mdu_state_e  : occupancy FSM states for multi-cycle MDU ops in EX
//   - stage_ctrl_t : enable/flush pair driving one inter-stage register
//   - hazard_t/HZ_*: encoding of the winning hazard after prioritisation
//   - stage()      : helper that builds a stage_ctrl_t from two bits
package pipeline_ctrl_pkg;

    // Width of the MDU occupancy down-counter.
    localparam int unsigned MDU_CNT_W = 4;

    typedef enum logic [0:0] {
        S_RUN = 1'b0,
        S_MDU = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

    // Winning hazard after prioritisation. Reset dominates everything,
    // then memory wait, MDU wait, redirect and finally load-use.
    typedef logic [2:0] hazard_t;

    localparam hazard_t HZ_NONE     = 3'd0;
    localparam hazard_t HZ_LOADUSE  = 3'd1;
    localparam hazard_t HZ_REDIRECT = 3'd2;
    localparam hazard_t HZ_MDUWAIT  = 3'd3;
    localparam hazard_t HZ_MEMWAIT  = 3'd4;
    localparam hazard_t HZ_RESET    = 3'd5;

    function automatic stage_ctrl_t stage(input logic en, input logic flush);
        stage_ctrl_t s;
        s.en    = en;
        s.flush = flush;
        return s;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect
//   Purely combinational load-use detector. Flags when the instruction in
//   EX is a load whose (non-zero) destination is read by the instruction
//   currently in ID.
//   Ports:
//     id_rs1, id_rs2 : source register indices of the ID instruction
//     ex_rd          : destination register index of the EX instruction
//     ex_mem_read    : EX instruction is a load
//     loaduse        : load-use hazard present
module hazard_detect #(
    parameter int unsigned REGADDR = 5
) (
    input  logic [REGADDR-1:0] id_rs1,
    input  logic [REGADDR-1:0] id_rs2,
    input  logic [REGADDR-1:0] ex_rd,
    input  logic               ex_mem_read,
    output logic               loaduse
);

    logic rd_nonzero;
    logic rs_match;

    always_comb begin
        // x0 is hard-wired zero, so a load into it never creates a hazard.
        rd_nonzero = (ex_rd != '0);
        rs_match   = (ex_rd == id_rs1) || (ex_rd == id_rs2);
        loaduse    = ex_mem_read && rd_nonzero && rs_match;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Central stall/flush controller for the 5-stage in-order core.
//   Drives the enable/flush of the IF/ID, ID/EX, EX/MEM and MEM/WB
//   registers plus the PC enable, resolving memory wait states, multi-cycle
//   MDU ops, load-use dependencies and taken branches. An occupancy FSM
//   tracks the MDU op in EX and a saturating counter records stall cycles.
//   Parameters:
//     REGADDR     : register-index width
//     MDU_LATENCY : cycles an MDU op occupies EX (>= 1)
//     CNTWIDTH    : stall-counter width
//   Ports:
//     clk_i, rst_i                : clock, synchronous active-high reset
//     id_rs1_i, id_rs2_i          : ID source registers
//     ex_rd_i                     : EX destination register
//     ex_mem_read_i               : EX holds a load
//     ex_mdu_i                    : EX holds an MDU op
//     ex_branch_taken_i           : EX redirects the PC
//     mem_req_i, mem_ack_i        : MEM data access and its completion
//     pc_en_o                     : PC update enable
//     *_en_o / *_flush_o          : stage-register enables / bubble inserts
//     mdu_busy_o                  : MDU stall active
//     stall_cnt_o                 : cycles with pc_en_o = 0 (not in reset)
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REGADDR     = 5,
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned CNTWIDTH    = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [REGADDR-1:0]  id_rs1_i,
    input  logic [REGADDR-1:0]  id_rs2_i,
    input  logic [REGADDR-1:0]  ex_rd_i,
    input  logic                ex_mem_read_i,
    input  logic                ex_mdu_i,
    input  logic                ex_branch_taken_i,
    input  logic                mem_req_i,
    input  logic                mem_ack_i,
    output logic                pc_en_o,
    output logic                if_id_en_o,
    output logic                id_ex_en_o,
    output logic                ex_mem_en_o,
    output logic                mem_wb_en_o,
    output logic                if_id_flush_o,
    output logic                id_ex_flush_o,
    output logic                ex_mem_flush_o,
    output logic                mem_wb_flush_o,
    output logic                mdu_busy_o,
    output logic [CNTWIDTH-1:0] stall_cnt_o
);

    // The op itself occupies the first EX cycle in S_RUN, so the counter
    // only has to cover the remaining MDU_LATENCY-2 stall cycles.
    localparam logic [MDU_CNT_W-1:0] CNT_START =
        (MDU_LATENCY > 1) ? MDU_CNT_W'(MDU_LATENCY - 2) : '0;
    localparam logic MDU_MULTI = (MDU_LATENCY > 1);

    mdu_state_e             state;
    logic [MDU_CNT_W-1:0]   cnt;
    logic [CNTWIDTH-1:0]    stall_cnt;

    logic        memwait;
    logic        mduwait;
    logic        mdu_start;
    logic        loaduse;
    logic        redirect;
    hazard_t     hazard;

    logic        pc_en;
    stage_ctrl_t if_id_c;
    stage_ctrl_t id_ex_c;
    stage_ctrl_t ex_mem_c;
    stage_ctrl_t mem_wb_c;

    hazard_detect #(
        .REGADDR (REGADDR)
    ) u_hazard_detect (
        .id_rs1      (id_rs1_i),
        .id_rs2      (id_rs2_i),
        .ex_rd       (ex_rd_i),
        .ex_mem_read (ex_mem_read_i),
        .loaduse     (loaduse)
    );

    // Hazard conditions.
    always_comb begin
        memwait   = mem_req_i && !mem_ack_i;
        redirect  = ex_branch_taken_i;
        mdu_start = (state == S_RUN) && ex_mdu_i && MDU_MULTI;
        // Reset aborts any MDU stall immediately, even before the FSM
        // register has been cleared by the edge.
        mduwait   = !rst_i &&
                    (mdu_start || ((state == S_MDU) && (cnt != '0)));
    end

    // Priority encode. Redirect sits above load-use but below both waits:
    // a branch only takes effect once EX is actually advancing.
    always_comb begin
        hazard = HZ_NONE;
        if (rst_i)         hazard = HZ_RESET;
        else if (memwait)  hazard = HZ_MEMWAIT;
        else if (mduwait)  hazard = HZ_MDUWAIT;
        else if (redirect) hazard = HZ_REDIRECT;
        else if (loaduse)  hazard = HZ_LOADUSE;
    end

    // Stage control mux.
    always_comb begin
        pc_en    = 1'b1;
        if_id_c  = stage(1'b1, 1'b0);
        id_ex_c  = stage(1'b1, 1'b0);
        ex_mem_c = stage(1'b1, 1'b0);
        mem_wb_c = stage(1'b1, 1'b0);
        case (hazard)
            HZ_RESET: begin
                pc_en    = 1'b0;
                if_id_c  = stage(1'b0, 1'b1);
                id_ex_c  = stage(1'b0, 1'b1);
                ex_mem_c = stage(1'b0, 1'b1);
                mem_wb_c = stage(1'b0, 1'b1);
            end
            HZ_MEMWAIT: begin
                // Everything up to EX/MEM freezes; a bubble enters WB.
                pc_en    = 1'b0;
                if_id_c  = stage(1'b0, 1'b0);
                id_ex_c  = stage(1'b0, 1'b0);
                ex_mem_c = stage(1'b0, 1'b0);
                mem_wb_c = stage(1'b1, 1'b1);
            end
            HZ_MDUWAIT: begin
                // Front end and EX hold; a bubble enters MEM, MEM drains.
                pc_en    = 1'b0;
                if_id_c  = stage(1'b0, 1'b0);
                id_ex_c  = stage(1'b0, 1'b0);
                ex_mem_c = stage(1'b1, 1'b1);
            end
            HZ_REDIRECT: begin
                // Squash the two younger instructions fetched down the
                // wrong path; PC takes the branch target.
                if_id_c  = stage(1'b1, 1'b1);
                id_ex_c  = stage(1'b1, 1'b1);
            end
            HZ_LOADUSE: begin
                // Hold IF/ID and the PC, send one bubble into EX.
                pc_en    = 1'b0;
                if_id_c  = stage(1'b0, 1'b0);
                id_ex_c  = stage(1'b1, 1'b1);
            end
            default: ;
        endcase
    end

    // MDU occupancy FSM. The counter keeps running during memory waits so
    // that overlapping stalls are not serialised. At cnt = 0 the FSM waits
    // in S_MDU until the op actually leaves EX, otherwise the still-held
    // ex_mdu_i would re-trigger the stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (mdu_start) begin
                        state <= S_MDU;
                        cnt   <= CNT_START;
                    end
                end
                S_MDU: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (id_ex_c.en) begin
                        state <= S_RUN;
                    end
                end
                default: begin
                    state <= S_RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (!pc_en && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNTWIDTH'(1);
        end
    end

    always_comb begin
        pc_en_o        = pc_en;
        if_id_en_o     = if_id_c.en;
        id_ex_en_o     = id_ex_c.en;
        ex_mem_en_o    = ex_mem_c.en;
        mem_wb_en_o    = mem_wb_c.en;
        if_id_flush_o  = if_id_c.flush;
        id_ex_flush_o  = id_ex_c.flush;
        ex_mem_flush_o = ex_mem_c.flush;
        mem_wb_flush_o = mem_wb_c.flush;
        mdu_busy_o     = mduwait;
        stall_cnt_o    = stall_cnt;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Scoreboard bench for pipeline_ctrl (MDU_LATENCY = 4). Each directed
//   vector pushes its hand-computed control word and stall count; a monitor
//   on the falling edge pops and compares against the DUT.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_mem_read, ex_mdu, ex_branch_taken, mem_req, mem_ack;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        mdu_busy;
    logic [31:0] stall_cnt;

    pipeline_ctrl #(
        .REGADDR     (5),
        .MDU_LATENCY (4),
        .CNTWIDTH    (32)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .id_rs1_i          (id_rs1),
        .id_rs2_i          (id_rs2),
        .ex_rd_i           (ex_rd),
        .ex_mem_read_i     (ex_mem_read),
        .ex_mdu_i          (ex_mdu),
        .ex_branch_taken_i (ex_branch_taken),
        .mem_req_i         (mem_req),
        .mem_ack_i         (mem_ack),
        .pc_en_o           (pc_en),
        .if_id_en_o        (if_id_en),
        .id_ex_en_o        (id_ex_en),
        .ex_mem_en_o       (ex_mem_en),
        .mem_wb_en_o       (mem_wb_en),
        .if_id_flush_o     (if_id_flush),
        .id_ex_flush_o     (id_ex_flush),
        .ex_mem_flush_o    (ex_mem_flush),
        .mem_wb_flush_o    (mem_wb_flush),
        .mdu_busy_o        (mdu_busy),
        .stall_cnt_o       (stall_cnt)
    );

    always #5 clk = ~clk;

    // Control word: {pc_en, if_id/id_ex/ex_mem/mem_wb en,
    //                if_id/id_ex/ex_mem/mem_wb flush, mdu_busy}
    localparam logic [9:0] C_DEF  = 10'b1_1111_0000_0;
    localparam logic [9:0] C_RST  = 10'b0_0000_1111_0;
    localparam logic [9:0] C_MEM  = 10'b0_0001_0001_0;
    localparam logic [9:0] C_MEMB = 10'b0_0001_0001_1;
    localparam logic [9:0] C_MDU  = 10'b0_0011_0010_1;
    localparam logic [9:0] C_LU   = 10'b0_0111_0100_0;
    localparam logic [9:0] C_RED  = 10'b1_1111_1100_0;

    typedef struct {
        string       name;
        logic [9:0]  ctrl;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   failed = 0;

    // Inputs apply just after the rising edge so the falling-edge monitor
    // sees settled combinational outputs for this cycle.
    task automatic step(input string nm, input logic r, input logic mr,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic mdu,
                        input logic br, input logic req, input logic ack,
                        input logic [9:0] ctrl, input logic [31:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; ex_mem_read = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        ex_mdu = mdu; ex_branch_taken = br; mem_req = req; mem_ack = ack;
        e.name = nm; e.ctrl = ctrl; e.cnt = cnt;
        q.push_back(e);
    endtask

    // Plain cycle with no hazard-relevant inputs apart from the flags given.
    task automatic idle(input string nm, input logic mdu, input logic br,
                        input logic req, input logic ack,
                        input logic [9:0] ctrl, input logic [31:0] cnt);
        step(nm, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, mdu, br, req, ack, ctrl, cnt);
    endtask

    always @(negedge clk) begin
        logic [9:0] act;
        exp_t e;
        if (q.size() != 0) begin
            e   = q.pop_front();
            act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                   mdu_busy};
            tests++;
            if (act !== e.ctrl) begin
                failed++;
                $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
            end
            tests++;
            if (stall_cnt !== e.cnt) begin
                failed++;
                $display("FAIL %s stall_cnt: got %0d expected %0d",
                         e.name, stall_cnt, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ex_mem_read = 1'b0; ex_rd = 5'd3; id_rs1 = 5'd1;
        id_rs2 = 5'd2; ex_mdu = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0;

        // Reset and default
        step("rst0", 1, 0, 5'd3, 5'd1, 5'd2, 0, 0, 0, 0, C_RST, 0);
        step("rst1", 1, 0, 5'd3, 5'd1, 5'd2, 0, 0, 0, 0, C_RST, 0);
        idle("idle", 0, 0, 0, 0, C_DEF, 0);

        // Load-use
        step("lu_rs1",  0, 1, 5'd5, 5'd5, 5'd2, 0, 0, 0, 0, C_LU, 0);
        idle("lu_rs1_after", 0, 0, 0, 0, C_DEF, 1);
        step("lu_rs2",  0, 1, 5'd5, 5'd3, 5'd5, 0, 0, 0, 0, C_LU, 1);
        idle("lu_rs2_after", 0, 0, 0, 0, C_DEF, 2);
        step("lu_x0",   0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, C_DEF, 2);
        step("lu_noload", 0, 0, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0, C_DEF, 2);

        // MDU stall, op held in EX for 4 cycles
        idle("mdu_c0", 1, 0, 0, 0, C_MDU, 2);
        idle("mdu_c1", 1, 0, 0, 0, C_MDU, 3);
        idle("mdu_c2", 1, 0, 0, 0, C_MDU, 4);
        idle("mdu_release", 1, 0, 0, 0, C_DEF, 5);
        idle("mdu_after", 0, 0, 0, 0, C_DEF, 5);

        // Memory wait, 5 cycles then ack
        for (int unsigned i = 0; i < 5; i++)
            idle($sformatf("memwait%0d", i), 0, 0, 1, 0, C_MEM, 5 + i);
        idle("mem_ack", 0, 0, 1, 1, C_DEF, 10);
        idle("mem_done", 0, 0, 0, 0, C_DEF, 10);

        // Branch under MDU stall
        idle("brmdu_c0", 1, 1, 0, 0, C_MDU, 10);
        idle("brmdu_c1", 1, 1, 0, 0, C_MDU, 11);
        idle("brmdu_c2", 1, 1, 0, 0, C_MDU, 12);
        idle("brmdu_redirect", 1, 1, 0, 0, C_RED, 13);
        idle("brmdu_after", 0, 0, 0, 0, C_DEF, 13);

        // Redirect overrides load-use; plain branch
        step("red_over_lu", 0, 1, 5'd5, 5'd5, 5'd2, 0, 1, 0, 0, C_RED, 13);
        idle("red_plain", 0, 1, 0, 0, C_RED, 13);
        idle("red_after", 0, 0, 0, 0, C_DEF, 13);

        // MDU entering with 2 memory-wait cycles: counter still expires
        idle("ovl_c0", 1, 0, 1, 0, C_MEMB, 13);
        idle("ovl_c1", 1, 0, 1, 0, C_MEMB, 14);
        idle("ovl_c2", 1, 0, 0, 0, C_MDU, 15);
        idle("ovl_release", 1, 0, 0, 0, C_DEF, 16);
        idle("ovl_after", 0, 0, 0, 0, C_DEF, 16);

        // Memory wait outlasts MDU: FSM must hold at cnt = 0
        idle("hold_c0", 1, 0, 1, 0, C_MEMB, 16);
        idle("hold_c1", 1, 0, 1, 0, C_MEMB, 17);
        idle("hold_c2", 1, 0, 1, 0, C_MEMB, 18);
        idle("hold_c3", 1, 0, 1, 0, C_MEM, 19);
        idle("hold_c4", 1, 0, 1, 0, C_MEM, 20);
        idle("hold_release", 1, 0, 0, 0, C_DEF, 21);
        idle("hold_after", 0, 0, 0, 0, C_DEF, 21);

        // Reset with cnt = 2 aborts the stall
        idle("rstmdu_c0", 1, 0, 0, 0, C_MDU, 21);
        step("rstmdu_rst", 1, 0, 5'd3, 5'd1, 5'd2, 1, 0, 0, 0, C_RST, 22);
        idle("rstmdu_post0", 0, 0, 0, 0, C_DEF, 0);
        idle("rstmdu_post1", 0, 0, 0, 0, C_DEF, 0);

        // Let the monitor drain the queue, bounded.
        for (int unsigned i = 0; i < 5; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
